dmem_line_ctrl: RTL and testbench

Line-granularity data memory that sits directly downstream of the L1 data cache. It serves 256-bit cache-line reads (refill) and writes (write-back) over an enable/write/ack handshake, with a fixed programmable access latency. It stands in for off-chip DRAM in CPU simulation. It is written as synthesizable RTL with a single-port line array.

---
 rtl/dmem_line_ctrl.sv | 98 +++++++++
 tb/tb_dmem_line_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_line_ctrl.sv
// Line-granularity backing memory behind the L1 data cache: one line read or
// write per enable/ack handshake, completing a fixed LATENCY edges after capture.
module dmem_line_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BITS  = 256,
  parameter int LINE_OFF   = 5,
  parameter int INDEX_BITS = 9,
  parameter int LATENCY    = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_enable_i,
  input  logic                  mem_write_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [LINE_BITS-1:0]  mem_data_i,
  output logic                  mem_ack_o,
  output logic [LINE_BITS-1:0]  mem_data_o,
  output logic                  busy_o
);

  localparam int NUM_LINES = 1 << INDEX_BITS;
  localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t                 state;
  logic [INDEX_BITS-1:0]  idx;
  logic                   wr_flag;
  logic [LINE_BITS-1:0]   wr_data;
  logic [CNT_W-1:0]       count;
  logic [LINE_BITS-1:0]   mem_array [NUM_LINES];

  logic [INDEX_BITS-1:0]  req_idx;
  logic                   complete;
  logic                   addr_unused;

  // Offset and upper address bits do not select a line; addresses alias.
  assign req_idx     = mem_addr_i[LINE_OFF+INDEX_BITS-1:LINE_OFF];
  assign addr_unused = ^{mem_addr_i[ADDR_WIDTH-1:LINE_OFF+INDEX_BITS],
                         mem_addr_i[LINE_OFF-1:0]};
  assign complete    = (state == BUSY) && (count == '0);

  // Array is never reset; a reset drops state to IDLE so no commit happens.
  always_ff @(posedge clk_i) begin
    if (complete && wr_flag) begin
      mem_array[idx] <= wr_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      idx        <= '0;
      wr_flag    <= 1'b0;
      wr_data    <= '0;
      count      <= '0;
      mem_ack_o  <= 1'b0;
      mem_data_o <= '0;
      busy_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_enable_i) begin
            idx     <= req_idx;
            wr_flag <= mem_write_i;
            wr_data <= mem_data_i;
            count   <= CNT_W'(LATENCY - 1);
            busy_o  <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (count != '0) begin
            count <= count - CNT_W'(1);
          end else begin
            if (!wr_flag) begin
              mem_data_o <= mem_array[idx];
            end
            mem_ack_o <= 1'b1;
            state     <= ACK;
          end
        end
        ACK: begin
          // Enable is deliberately ignored here; the next request waits for IDLE.
          mem_ack_o <= 1'b0;
          busy_o    <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          mem_ack_o <= 1'b0;
          busy_o    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Bench for dmem_line_ctrl: a timing/content model of two instances (default
// and LATENCY=1/INDEX_BITS=4) checked every cycle, plus directed literal checks.
module tb_dmem_line_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         en    [2];
  logic         wr    [2];
  logic [31:0]  addr  [2];
  logic [255:0] wdata [2];
  logic         ack   [2];
  logic         busy  [2];
  logic [255:0] rdata [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_line_ctrl u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .mem_enable_i(en[0]), .mem_write_i(wr[0]), .mem_addr_i(addr[0]), .mem_data_i(wdata[0]),
    .mem_ack_o(ack[0]), .mem_data_o(rdata[0]), .busy_o(busy[0])
  );

  dmem_line_ctrl #(.LATENCY(1), .INDEX_BITS(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .mem_enable_i(en[1]), .mem_write_i(wr[1]), .mem_addr_i(addr[1]), .mem_data_i(wdata[1]),
    .mem_ack_o(ack[1]), .mem_data_o(rdata[1]), .busy_o(busy[1])
  );

  function automatic logic [255:0] pre(input int k);
    if (k == 3) return {32{8'hA5}};
    return {32{k[7:0]}};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Model: a request seen at edge S completes at edge S+lat (ack for one cycle)
  // and the instance is free again from edge S+lat+2.
  int           lat   [2] = '{10, 1};
  int           ibits [2] = '{9, 4};
  longint       ecnt = 0;
  bit           act   [2];
  longint       st    [2];
  logic         m_wr  [2];
  int           m_idx [2];
  logic [255:0] m_d   [2];
  bit           valid_w [2][512];
  logic [255:0] mw      [2][512];
  logic         exp_ack  [2];
  logic         exp_busy [2];
  logic [255:0] exp_data [2];

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        act[i]      <= 1'b0;
        exp_ack[i]  <= 1'b0;
        exp_busy[i] <= 1'b0;
        exp_data[i] <= '0;
      end else begin
        exp_ack[i] <= 1'b0;
        if (act[i]) begin
          if (ecnt == st[i] + lat[i]) begin
            exp_ack[i] <= 1'b1;
            if (m_wr[i]) begin
              mw[i][m_idx[i]]      <= m_d[i];
              valid_w[i][m_idx[i]] <= 1'b1;
            end else begin
              exp_data[i] <= valid_w[i][m_idx[i]] ? mw[i][m_idx[i]] : pre(m_idx[i]);
            end
          end else if (ecnt == st[i] + lat[i] + 1) begin
            act[i]      <= 1'b0;
            exp_busy[i] <= 1'b0;
          end
        end else if (en[i]) begin
          act[i]      <= 1'b1;
          st[i]       <= ecnt;
          m_wr[i]     <= wr[i];
          m_idx[i]    <= int'((addr[i] >> 5) & ((32'd1 << ibits[i]) - 32'd1));
          m_d[i]      <= wdata[i];
          exp_busy[i] <= 1'b1;
        end
      end
    end
    if (rst) ecnt <= ecnt + 1;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ack%0d@%0t", i, $time),  {255'd0, ack[i]},  {255'd0, exp_ack[i]});
      chk($sformatf("busy%0d@%0t", i, $time), {255'd0, busy[i]}, {255'd0, exp_busy[i]});
      chk($sformatf("data%0d@%0t", i, $time), rdata[i], exp_data[i]);
    end
  end

  // Counts edges from the call until ack is seen just after an edge.
  task automatic wait_ack(input int k, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack[k] && n < 200);
    if (!ack[k]) begin
      total++;
      bad++;
      $display("FAIL ack_timeout inst=%0d got=no_ack want=ack", k);
    end
  endtask

  task automatic settle(input int k);
    en[k] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic drive(input int k, input logic w, input logic [31:0] a, input logic [255:0] d);
    en[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    for (int k = 0; k < 512; k++) u_dut0.mem_array[k] = pre(k);
    for (int k = 0; k < 16; k++)  u_dut1.mem_array[k] = pre(k);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    chk("reset_ack",  {255'd0, ack[0]},  256'd0);
    chk("reset_busy", {255'd0, busy[0]}, 256'd0);
    chk("reset_data", rdata[0], 256'd0);

    // 1: read line 3
    @(negedge clk); #1;
    drive(0, 1'b0, 32'h60, '0);
    wait_ack(0, n);
    en[0] = 1'b0;
    chk("t1_latency", 256'(n), 256'd11);
    chk("t1_data", rdata[0], {32{8'hA5}});
    @(posedge clk); #1;
    chk("t1_ack_width", {255'd0, ack[0]}, 256'd0);
    chk("t1_data_held", rdata[0], {32{8'hA5}});

    // 2: write line 4, read it back through a different offset
    settle(0);
    drive(0, 1'b1, 32'h80, {8{32'hDEADBEEF}});
    wait_ack(0, n);
    chk("t2_write_keeps_data", rdata[0], {32{8'hA5}});
    settle(0);
    drive(0, 1'b0, 32'h9F, '0);
    wait_ack(0, n);
    chk("t2_read_back", rdata[0], {8{32'hDEADBEEF}});

    // 3: write-back then refill with enable held high
    settle(0);
    drive(0, 1'b1, 32'h20, {8{32'hCAFEF00D}});
    wait_ack(0, n);
    chk("t3_first_latency", 256'(n), 256'd11);
    wr[0] = 1'b0; addr[0] = 32'h4020;
    wait_ack(0, n);
    en[0] = 1'b0;
    chk("t3_ack_spacing", 256'(n), 256'd12);
    chk("t3_refill", rdata[0], {8{32'hCAFEF00D}});

    // 4: enable dropped and address changed mid-transaction
    settle(0);
    drive(0, 1'b0, 32'h40, '0);
    repeat (3) @(posedge clk); #1;
    en[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h1E0;
    wait_ack(0, n);
    chk("t4_latency", 256'(n), 256'd8);
    chk("t4_orig_addr", rdata[0], {32{8'h02}});
    repeat (20) @(posedge clk); #1;
    chk("t4_no_second", {255'd0, busy[0]}, 256'd0);

    // 5: reset during a write to line 7
    settle(0);
    drive(0, 1'b1, 32'hE0, {256{1'b1}});
    repeat (4) @(posedge clk); #1;
    rst = 1'b0; en[0] = 1'b0;
    #1;
    chk("t5_rst_ack",  {255'd0, ack[0]},  256'd0);
    chk("t5_rst_busy", {255'd0, busy[0]}, 256'd0);
    chk("t5_rst_data", rdata[0], 256'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk); #1;
    drive(0, 1'b0, 32'hE0, '0);
    wait_ack(0, n);
    en[0] = 1'b0;
    chk("t5_latency", 256'(n), 256'd11);
    chk("t5_line7_kept", rdata[0], {32{8'h07}});

    // 6: LATENCY=1, 16-line instance with address wrap
    settle(1);
    drive(1, 1'b1, 32'hA0, {8{32'h600D_0006}});
    wait_ack(1, n);
    chk("t6_write_latency", 256'(n), 256'd2);
    settle(1);
    drive(1, 1'b0, 32'h2A0, '0);
    wait_ack(1, n);
    en[1] = 1'b0;
    chk("t6_read_latency", 256'(n), 256'd2);
    chk("t6_wrap_data", rdata[1], {8{32'h600D_0006}});

    repeat (4) @(posedge clk);
    @(negedge clk); #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
